// File: rtl/product_accumulator.sv
// Accumulates 8-bit products over a frame into a saturating sum and beat count,
// presenting each frame result through a one-entry valid/ready output register.
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       p,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               oovf_q, oovf_d;

  logic [ACC_W:0]     nsum;
  logic [ACC_W-1:0]   sat_sum;
  logic               ovf_term;
  logic [CNT_W-1:0]   ncnt;
  logic               accept;

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // One extra bit of headroom exposes the carry used for saturation.
  assign nsum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, p};
  assign ovf_term = nsum[ACC_W];
  assign sat_sum  = ovf_term ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
  assign ncnt     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    count_d = count_q;
    oovf_d  = oovf_q;
    if (accept && in_last) begin
      sum_d   = sat_sum;
      count_d = ncnt;
      oovf_d  = ovf_q | ovf_term;
      state_d = FULL;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (accept) begin
        acc_d = sat_sum;
        cnt_d = ncnt;
        ovf_d = ovf_q | ovf_term;
      end
      if (state_q == FULL && out_ready) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      oovf_q  <= oovf_d;
    end
  end

  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = oovf_q;

endmodule
